// File: rtl/flappy_game_ctrl_pkg.sv
// Shared types and constants for the flappy bird game sequencer.
package flappy_pkg;

  localparam int unsigned SCORE_W   = 10;
  localparam int unsigned SCORE_MAX = 999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Board-side event/control bundle of the game sequencer; slave is the controller side.
interface flappy_game_ctrl_if;

  logic                           i_btn;
  logic                           i_out_of_bounds;
  logic                           i_collide;
  logic                           i_pass;
  logic                           o_physics_stb;
  logic                           o_bird_rst;
  logic                           o_animate;
  logic                           o_flap;
  logic [1:0]                     o_state;
  logic [flappy_pkg::SCORE_W-1:0] o_score;
  logic [flappy_pkg::SCORE_W-1:0] o_hi_score;

  modport master (
    output i_btn, i_out_of_bounds, i_collide, i_pass,
    input  o_physics_stb, o_bird_rst, o_animate, o_flap, o_state, o_score, o_hi_score
  );

  modport slave (
    input  i_btn, i_out_of_bounds, i_collide, i_pass,
    output o_physics_stb, o_bird_rst, o_animate, o_flap, o_state, o_score, o_hi_score
  );

endinterface

// File: rtl/flappy_game_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability debounce, one-cycle press pulse on
// an accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any return of the synced level to the accepted level restarts the stability count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: physics tick divider, IDLE/PLAY/DYING/OVER FSM, score and high score.
module flappy_game_ctrl
  import flappy_pkg::SCORE_W, flappy_pkg::state_e, flappy_pkg::ST_IDLE, flappy_pkg::ST_PLAY,
         flappy_pkg::ST_DYING, flappy_pkg::ST_OVER;
#(
  parameter int unsigned PHYS_DIV     = 1666667,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned DEATH_TICKS  = 60,
  parameter int unsigned SCORE_MAX    = flappy_pkg::SCORE_MAX
) (
  input logic               i_clk,
  input logic               i_rst,
  flappy_game_ctrl_if.slave bus
);

  localparam int unsigned TICK_W  = $clog2(PHYS_DIV);
  localparam int unsigned DEATH_W = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(PHYS_DIV - 1);
  localparam logic [DEATH_W-1:0] DEATH_LAST = DEATH_W'(DEATH_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(SCORE_MAX);

  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [DEATH_W-1:0]   death_q, death_d;
  logic [SCORE_W-1:0]   score_q, score_d, hi_q, hi_d;
  logic                 stb_q, stb_d, bird_rst_q, bird_rst_d;
  logic                 animate_q, animate_d, flap_q, flap_d;
  logic                 tick, press, dead;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (bus.i_btn),
    .o_press (press)
  );

  assign tick   = (tick_q == TICK_LAST);
  assign tick_d = tick ? '0 : tick_q + TICK_W'(1);
  assign dead   = bus.i_out_of_bounds | bus.i_collide;

  // Next state plus registered-output precompute; a death event masks pass and press.
  always_comb begin
    state_d = state_q;
    death_d = death_q;
    score_d = score_q;
    hi_d    = hi_q;
    flap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_PLAY;
          score_d = '0;
          flap_d  = 1'b1;
        end
      end
      ST_PLAY: begin
        death_d = '0;
        if (dead) begin
          state_d = ST_DYING;
        end else begin
          flap_d = press;
          if (bus.i_pass && (score_q < SCORE_LAST)) score_d = score_q + SCORE_W'(1);
        end
      end
      ST_DYING: begin
        if (tick) begin
          if (death_q == DEATH_LAST) begin
            state_d = ST_OVER;
            if (score_q > hi_q) hi_d = score_q;
          end else begin
            death_d = death_q + DEATH_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    stb_d      = tick & (state_d == ST_PLAY);
    bird_rst_d = (state_d == ST_IDLE);
    animate_d  = (state_d == ST_PLAY);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      death_q    <= '0;
      score_q    <= '0;
      hi_q       <= '0;
      stb_q      <= 1'b0;
      bird_rst_q <= 1'b1;
      animate_q  <= 1'b0;
      flap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      death_q    <= death_d;
      score_q    <= score_d;
      hi_q       <= hi_d;
      stb_q      <= stb_d;
      bird_rst_q <= bird_rst_d;
      animate_q  <= animate_d;
      flap_q     <= flap_d;
    end
  end

  assign bus.o_state       = state_q;
  assign bus.o_physics_stb = stb_q;
  assign bus.o_bird_rst    = bird_rst_q;
  assign bus.o_animate     = animate_q;
  assign bus.o_flap        = flap_q;
  assign bus.o_score       = score_q;
  assign bus.o_hi_score    = hi_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl with PHYS_DIV=4, DEBOUNCE_CYC=3, DEATH_TICKS=2.
module tb_flappy_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   flaps, stbs;
  logic [1:0] flap_state;

  always #5 clk = ~clk;

  flappy_game_ctrl_if bus ();

  flappy_game_ctrl #(.PHYS_DIV(4), .DEBOUNCE_CYC(3), .DEATH_TICKS(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_count();
    step();
    flaps += int'(bus.o_flap);
    stbs  += int'(bus.o_physics_stb);
    if (bus.o_flap) flap_state = bus.o_state;
  endtask

  // Clean press: button held for 6 edges, then released and allowed to settle.
  task automatic press_btn();
    flaps = 0;
    bus.i_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step_count();
      if (i == 5) bus.i_btn = 1'b0;
    end
  endtask

  task automatic pulse_pass(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_pass = 1'b1;
      step();
      bus.i_pass = 1'b0;
      step();
    end
  endtask

  task automatic die_oob(input string tag);
    bus.i_out_of_bounds = 1'b1;
    step();
    bus.i_out_of_bounds = 1'b0;
    check({tag, "_dying"}, 32'(bus.o_state), 32'd2);
    for (int i = 0; i < 12 && bus.o_state != 2'd3; i++) step();
    check({tag, "_over"}, 32'(bus.o_state), 32'd3);
  endtask

  task automatic wait_stb(input string tag);
    for (int i = 0; i < 8 && !bus.o_physics_stb; i++) step();
    check(tag, 32'(bus.o_physics_stb), 32'd1);
  endtask

  initial begin
    bus.i_btn = 1'b0;
    bus.i_out_of_bounds = 1'b0;
    bus.i_collide = 1'b0;
    bus.i_pass = 1'b0;
    flaps = 0;
    stbs = 0;
    flap_state = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_state", 32'(bus.o_state), 32'd0);
    check("rst_bird_rst", 32'(bus.o_bird_rst), 32'd1);
    check("rst_flap", 32'(bus.o_flap), 32'd0);
    check("rst_stb", 32'(bus.o_physics_stb), 32'd0);
    check("rst_animate", 32'(bus.o_animate), 32'd0);
    check("rst_score", 32'(bus.o_score), 32'd0);
    check("rst_hi", 32'(bus.o_hi_score), 32'd0);
    step();

    bus.i_out_of_bounds = 1'b1;
    repeat (4) step();
    bus.i_out_of_bounds = 1'b0;
    check("idle_oob_state", 32'(bus.o_state), 32'd0);
    check("idle_oob_stb", 32'(bus.o_physics_stb), 32'd0);

    // Two-cycle glitch must not survive the 3-cycle debounce.
    bus.i_btn = 1'b1;
    step();
    step();
    bus.i_btn = 1'b0;
    flaps = 0;
    repeat (8) step_count();
    check("glitch_flaps", 32'(flaps), 32'd0);
    check("glitch_state", 32'(bus.o_state), 32'd0);

    flap_state = 2'd0;
    press_btn();
    check("start_flaps", 32'(flaps), 32'd1);
    check("start_flap_state", 32'(flap_state), 32'd1);
    check("start_state", 32'(bus.o_state), 32'd1);
    check("start_animate", 32'(bus.o_animate), 32'd1);
    check("start_bird_rst", 32'(bus.o_bird_rst), 32'd0);
    check("start_score", 32'(bus.o_score), 32'd0);

    wait_stb("stb_first");
    stbs = 0;
    repeat (3) step_count();
    check("stb_gap", 32'(stbs), 32'd0);
    step_count();
    check("stb_4th", 32'(bus.o_physics_stb), 32'd1);
    stbs = 0;
    repeat (8) step_count();
    check("stb_rate", 32'(stbs), 32'd2);

    pulse_pass(3);
    check("score3", 32'(bus.o_score), 32'd3);

    // Align so death, pass and press all land on a tick edge n+8.
    wait_stb("coll_align");
    step();
    step();
    bus.i_btn = 1'b1;
    repeat (5) step();
    bus.i_btn = 1'b0;
    bus.i_collide = 1'b1;
    bus.i_pass = 1'b1;
    step();
    bus.i_collide = 1'b0;
    bus.i_pass = 1'b0;
    check("coll_state", 32'(bus.o_state), 32'd2);
    check("coll_flap", 32'(bus.o_flap), 32'd0);
    check("coll_score", 32'(bus.o_score), 32'd3);
    check("coll_stb", 32'(bus.o_physics_stb), 32'd0);
    check("coll_animate", 32'(bus.o_animate), 32'd0);
    flaps = 0;
    stbs = 0;
    repeat (7) step_count();
    check("coll_still_dying", 32'(bus.o_state), 32'd2);
    check("coll_dying_stbs", 32'(stbs), 32'd0);
    check("coll_dying_flaps", 32'(flaps), 32'd0);
    step();
    check("coll_over", 32'(bus.o_state), 32'd3);
    check("coll_hi", 32'(bus.o_hi_score), 32'd3);

    bus.i_out_of_bounds = 1'b1;
    repeat (4) step();
    bus.i_out_of_bounds = 1'b0;
    check("over_oob_state", 32'(bus.o_state), 32'd3);
    pulse_pass(1);
    check("over_pass_score", 32'(bus.o_score), 32'd3);

    press_btn();
    check("over_press_state", 32'(bus.o_state), 32'd0);
    check("over_press_bird_rst", 32'(bus.o_bird_rst), 32'd1);
    check("over_press_flaps", 32'(flaps), 32'd0);
    check("idle_score_held", 32'(bus.o_score), 32'd3);

    press_btn();
    check("g2_state", 32'(bus.o_state), 32'd1);
    check("g2_score0", 32'(bus.o_score), 32'd0);
    press_btn();
    check("g2_play_flaps", 32'(flaps), 32'd1);
    check("g2_play_state", 32'(bus.o_state), 32'd1);
    pulse_pass(4);
    die_oob("g2");
    check("g2_hi", 32'(bus.o_hi_score), 32'd4);
    check("g2_score", 32'(bus.o_score), 32'd4);
    press_btn();
    check("g2_idle", 32'(bus.o_state), 32'd0);

    press_btn();
    check("g3_state", 32'(bus.o_state), 32'd1);
    pulse_pass(2);
    die_oob("g3");
    check("g3_hi", 32'(bus.o_hi_score), 32'd4);
    check("g3_score", 32'(bus.o_score), 32'd2);
    press_btn();
    check("g3_idle_score", 32'(bus.o_score), 32'd2);

    press_btn();
    pulse_pass(5);
    check("g4_score", 32'(bus.o_score), 32'd5);
    check("g4_hi", 32'(bus.o_hi_score), 32'd4);

    // Reset mid-game with a press already in the synchroniser.
    bus.i_btn = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(bus.o_state), 32'd0);
    check("mid_rst_bird_rst", 32'(bus.o_bird_rst), 32'd1);
    check("mid_rst_score", 32'(bus.o_score), 32'd0);
    check("mid_rst_hi", 32'(bus.o_hi_score), 32'd0);
    check("mid_rst_animate", 32'(bus.o_animate), 32'd0);
    bus.i_btn = 1'b0;
    step();
    step();
    rst = 1'b0;
    flaps = 0;
    repeat (8) step_count();
    check("mid_rst_no_flap", 32'(flaps), 32'd0);
    check("mid_rst_idle", 32'(bus.o_state), 32'd0);

    press_btn();
    check("sat_state", 32'(bus.o_state), 32'd1);
    bus.i_pass = 1'b1;
    repeat (999) step();
    check("sat_999", 32'(bus.o_score), 32'd999);
    step();
    check("sat_hold", 32'(bus.o_score), 32'd999);
    bus.i_pass = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
